// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the core's load/store path:
// RV32I size codes, responder state encoding and the funct3 legality check.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   // Stores only have signed-size codes; loads add the unsigned variants.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

endpackage

// File: rtl/load_align_extend.sv
// Selects the addressed byte/half/word of a little-endian 32-bit word and extends it.
// Flags misaligned half/word accesses; illegal size codes return zero.
module load_align_extend
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        misalign
);

   logic [31:0] shifted;

   assign shifted = word >> {addr_lo, 3'b000};

   always_comb begin
      rdata    = 32'h0;
      misalign = 1'b0;
      case (funct3)
         F3_B:  rdata = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU: rdata = {24'h0, shifted[7:0]};
         F3_H: begin
            misalign = addr_lo[0];
            rdata    = {{16{shifted[15]}}, shifted[15:0]};
         end
         F3_HU: begin
            misalign = addr_lo[0];
            rdata    = {16'h0, shifted[15:0]};
         end
         F3_W: begin
            misalign = (addr_lo != 2'b00);
            rdata    = word;
         end
         default: rdata = 32'h0;
      endcase
      if (misalign) rdata = 32'h0;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one outstanding load/store, served from a word RAM after
// WAIT_CYCLES wait states, with the response held until the consumer takes it.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]   off;
   logic          in_range;
   logic [AW-1:0] idx;
   logic [31:0]   ld_rdata;
   logic          ld_mis;
   logic          st_mis;
   logic [3:0]    be;
   logic [31:0]   wdata_al;
   logic          acc_err;
   logic          mem_we;

   // BASE_ADDR is aligned to the span, so an address below it wraps to a large offset.
   assign off      = addr_q - BASE_ADDR;
   assign in_range = ({1'b0, off} < SPAN);
   assign idx      = off[AW+1:2];

   load_align_extend u_lae (
      .word     (mem[idx]),
      .addr_lo  (addr_q[1:0]),
      .funct3   (f3_q),
      .rdata    (ld_rdata),
      .misalign (ld_mis)
   );

   always_comb begin
      be       = 4'b0000;
      wdata_al = wdata_q;
      st_mis   = 1'b0;
      case (f3_q)
         F3_B: begin
            be       = 4'b0001 << addr_q[1:0];
            wdata_al = {4{wdata_q[7:0]}};
         end
         F3_H: begin
            be       = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_al = {2{wdata_q[15:0]}};
            st_mis   = addr_q[0];
         end
         F3_W: begin
            be     = 4'b1111;
            st_mis = (addr_q[1:0] != 2'b00);
         end
         default: be = 4'b0000;
      endcase
   end

   assign acc_err = !in_range || !f3_legal(we_q, f3_q) || (we_q ? st_mis : ld_mis);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               f3_d    = req_funct3;
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_ACCESS;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_ACCESS: begin
            err_d   = acc_err;
            rdata_d = (we_q || acc_err) ? 32'h0 : ld_rdata;
            mem_we  = we_q && !acc_err;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         f3_q    <= 3'b000;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // RAM is never cleared; reset only blocks a write racing the ACCESS edge.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
         end
      end
   end

   assign req_ready  = (state_q == S_IDLE) && !reset;
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default 2-wait-state instance plus a
// zero-wait instance for the back-to-back handshake timing.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid0, req_ready0, req_we0;
   logic [31:0] req_addr0, req_wdata0;
   logic [2:0]  req_funct30;
   logic        resp_valid0, resp_ready0, resp_err0;
   logic [31:0] resp_rdata0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
      .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0),
      .resp_rdata(resp_rdata0), .resp_err(resp_err0)
   );

   // Drives one request on the main instance and collects its response.
   // lat counts rising edges from accept until resp_valid is seen.
   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic [31:0] rd, output logic er,
                         output int lat);
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = 32'hx; req_addr = 32'hx;
      lat = 0;
      while (!resp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got rdy=%b vld=%b rdata=%h err=%b want 0 0 0 0",
                  req_ready, resp_valid, resp_rdata, resp_err);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready got %b/%b want 1/1", req_ready, req_ready0);
      end
   endtask

   task automatic test_word;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
      checks++;
      if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
         failures++;
         $display("FAIL sw_resp got rdata=%h err=%b lat=%0d want 0 0 3", rd, er, lat);
      end
      do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
         failures++;
         $display("FAIL lw_resp got rdata=%h err=%b lat=%0d want deadbeef 0 3", rd, er, lat);
      end
   endtask

   task automatic test_subword_loads;
      logic [31:0] rd; logic er; int lat;
      logic [31:0] exp_b  [4];
      logic [31:0] exp_bu [4];
      exp_b  = '{32'hFFFFFFEF, 32'hFFFFFFBE, 32'hFFFFFFAD, 32'hFFFFFFDE};
      exp_bu = '{32'h000000EF, 32'h000000BE, 32'h000000AD, 32'h000000DE};
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, 32'h10 + 32'(i), 32'h0, 3'b000, rd, er, lat);
         checks++;
         if (rd !== exp_b[i] || er !== 1'b0) begin
            failures++;
            $display("FAIL lb_%0d got %h err=%b want %h 0", i, rd, er, exp_b[i]);
         end
         do_req(1'b0, 32'h10 + 32'(i), 32'h0, 3'b100, rd, er, lat);
         checks++;
         if (rd !== exp_bu[i] || er !== 1'b0) begin
            failures++;
            $display("FAIL lbu_%0d got %h err=%b want %h 0", i, rd, er, exp_bu[i]);
         end
      end
      do_req(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lat);
      checks++;
      if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin
         failures++;
         $display("FAIL lh_12 got %h err=%b want ffffdead 0", rd, er);
      end
      do_req(1'b0, 32'h12, 32'h0, 3'b101, rd, er, lat);
      checks++;
      if (rd !== 32'h0000DEAD || er !== 1'b0) begin
         failures++;
         $display("FAIL lhu_12 got %h err=%b want 0000dead 0", rd, er);
      end
   endtask

   task automatic test_subword_stores;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h11, 32'hAAAAAA55, 3'b000, rd, er, lat);
      do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      checks++;
      if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
         failures++;
         $display("FAIL sb_merge got %h err=%b want dead55ef 0", rd, er);
      end
      do_req(1'b1, 32'h12, 32'hBBBB1234, 3'b001, rd, er, lat);
      do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      checks++;
      if (rd !== 32'h123455EF || er !== 1'b0) begin
         failures++;
         $display("FAIL sh_merge got %h err=%b want 123455ef 0", rd, er);
      end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er; int lat;
      logic        t_we [4];
      logic [31:0] t_a  [4];
      logic [2:0]  t_f3 [4];
      t_we = '{1'b0, 1'b1, 1'b0, 1'b0};
      t_a  = '{32'h13, 32'h11, 32'h100, 32'h10};
      t_f3 = '{3'b010, 3'b001, 3'b010, 3'b011};
      for (int i = 0; i < 4; i++) begin
         do_req(t_we[i], t_a[i], 32'hFFFFFFFF, t_f3[i], rd, er, lat);
         checks++;
         if (rd !== 32'h0 || er !== 1'b1 || lat !== 3) begin
            failures++;
            $display("FAIL err_case_%0d got rdata=%h err=%b lat=%0d want 0 1 3", i, rd, er, lat);
         end
      end
      do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      checks++;
      if (rd !== 32'h123455EF || er !== 1'b0) begin
         failures++;
         $display("FAIL err_no_write got %h err=%b want 123455ef 0", rd, er);
      end
   endtask

   task automatic test_stall;
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      while (!resp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'h123455EF || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_%0d got vld=%b rdata=%h rdy=%b want 1 123455ef 0",
                     c, resp_valid, resp_rdata, req_ready);
         end
         @(posedge clk); #1;
      end
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL stall_release got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      resp_ready0 = 1'b1;
      req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h0;
      req_wdata0 = 32'hCAFEF00D; req_funct30 = 3'b010;
      @(posedge clk); #1;
      checks++;
      if (req_ready0 !== 1'b0 || resp_valid0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_access got rdy=%b vld=%b want 0 0", req_ready0, resp_valid0);
      end
      req_we0 = 1'b0; req_wdata0 = 32'h0;
      @(posedge clk); #1;
      checks++;
      if (resp_valid0 !== 1'b1 || req_ready0 !== 1'b0 || resp_err0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_resp1 got vld=%b rdy=%b err=%b want 1 0 0", resp_valid0, req_ready0, resp_err0);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_bubble got vld=%b rdy=%b want 0 1", resp_valid0, req_ready0);
      end
      @(posedge clk); #1;
      checks++;
      if (req_ready0 !== 1'b0 || resp_valid0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept2 got rdy=%b vld=%b want 0 0", req_ready0, resp_valid0);
      end
      req_valid0 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (resp_valid0 !== 1'b1 || resp_rdata0 !== 32'hCAFEF00D || resp_err0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_resp2 got vld=%b rdata=%h err=%b want 1 cafef00d 0",
                  resp_valid0, resp_rdata0, resp_err0);
      end
      @(posedge clk); #1;
      resp_ready0 = 1'b0;
   endtask

   task automatic test_reset_mid_wait;
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 32'h20, 32'h11111111, 3'b010, rd, er, lat);
      do_req(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
      req_wdata = 32'hA5A5A5A5; req_funct3 = 3'b010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0 || resp_rdata !== 32'h11111111) begin
         failures++;
         $display("FAIL rst_pre got rdy=%b rdata=%h want 0 11111111", req_ready, resp_rdata);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_wait got vld=%b rdata=%h err=%b rdy=%b want 0 0 0 0",
                  resp_valid, resp_rdata, resp_err, req_ready);
      end
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      do_req(1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
      checks++;
      if (rd !== 32'h11111111 || er !== 1'b0) begin
         failures++;
         $display("FAIL rst_no_write got %h err=%b want 11111111 0", rd, er);
      end
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b0;
      resp_ready = 1'b0;
      req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; req_funct30 = 3'b0;
      resp_ready0 = 1'b0;
      test_reset;
      test_word;
      test_subword_loads;
      test_subword_stores;
      test_errors;
      test_stall;
      test_back_to_back;
      test_reset_mid_wait;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Target-side responder for the core's data-memory port. Accepts load/store requests over a valid/ready handshake and serves them from an internal word-organised RAM after a programmable number of wait states. Returns sign- or zero-extended load data, or a store acknowledge, through a second valid/ready channel. Sits between the processor's load/store path and backing storage, and lets the core be exercised against non-zero-latency memory.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the RAM; must be a power of 2.
WAIT_CYCLES, 2, wait states between request accept and RAM access; range 0..15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high; clears all control state.
req_valid  in  1  a request is presented.
req_ready  out  1  the responder can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data; the low bytes are used for SB/SH.
req_funct3  in  3  RV32I size/sign code.
resp_valid  out  1  a response is held.
resp_ready  in  1  the consumer takes the response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  the request was misaligned, out of range or an illegal funct3.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- On reset:
  - state goes to IDLE; req_ready=0 while reset is asserted, then 1 in IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - RAM contents are not cleared.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/funct3. Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: the counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Go to ACCESS when the counter is 0.
  - ACCESS: one cycle. Perform the RAM write or read, compute rdata/err, then go to RESP.
  - RESP: resp_valid=1. Outputs stay stable until resp_ready. On resp_valid&&resp_ready, go to IDLE and clear resp_valid.
  - req_ready=0 in WAIT, ACCESS and RESP. Only one request is outstanding at a time.
- Latency: accept at edge N gives resp_valid high after edge N+WAIT_CYCLES+1. That is 3 cycles at the default WAIT_CYCLES=2.
- funct3 for loads:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half.
  - 010 LW.
  - 100 LBU and 101 LHU: zero-extend.
- funct3 for stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 is an error.
- Byte order is little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- Stores write only the selected byte enables; the other bytes of the word are preserved.
- Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after the range check.
- Errors:
  - Triggers: halfword with addr[0]=1, word with addr[1:0]!=0, addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), or illegal funct3.
  - Response: resp_err=1 and resp_rdata=0. No RAM write occurs. The response handshake still completes.
- Stores respond with resp_err only and resp_rdata=0.
- Back-to-back requests: a request presented during the resp_ready cycle is not accepted that cycle. It is accepted in the following IDLE cycle, so there is a 1-cycle bubble.
- Reset mid-operation: a request in WAIT is discarded with no write. A write takes effect only at the ACCESS edge. A pending response is dropped.
- The request fields need to be stable only in the accept cycle.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state encoding: IDLE, WAIT, ACCESS, RESP as a 2-bit enum.
- Sub-module load_align_extend, combinational:
  - inputs: 32-bit word, addr[1:0], funct3.
  - outputs: extended rdata and a misalign flag.
  - reused by the core's writeback path.
- The byte-enable generation for stores stays inline.

Test Plan:
1. SW 0xDEADBEEF at 0x10, then LW at 0x10 → rdata 0xDEADBEEF, err 0. resp_valid rises exactly 3 cycles after accept.
2. Walk LB/LBU over 0x10..0x13 → 0xFFFFFFEF/0x000000EF, 0xFFFFFFBE/0xBE, 0xFFFFFFAD/0xAD, 0xFFFFFFDE/0xDE. Then LH/LHU at 0x12 → 0xFFFFDEAD/0x0000DEAD.
3. SB 0x55 at 0x11, then LW 0x10 → 0xDEAD55EF. SH 0x1234 at 0x12, then LW → 0x123455EF.
4. LW at 0x13, SH at 0x11, LW at 0x100 (DEPTH 64) and funct3=011 → each gives err=1 and rdata=0. A follow-up LW 0x10 shows the word unchanged.
5. Hold resp_ready=0 for 5 cycles → resp_valid/rdata stay stable and req_ready stays 0. Then check back-to-back requests with WAIT_CYCLES=0: accept, response after 1 cycle, 1-cycle bubble before the next accept.
6. Assert reset during WAIT of an SW 0xA5A5A5A5 to 0x20 that follows an earlier SW 0x11111111 → outputs go 0 immediately. After release, LW 0x20 returns 0x11111111.
